pipe_fetch: RTL and testbench
=============================

# pipe_fetch

Instruction-fetch (IF) stage and IF/ID pipeline register of the 5-stage RV32I core. It sits directly upstream of the ID-stage control decoder. It owns the PC, drives the instruction-memory address, and latches {PC, PC+4, instruction, valid} into IF/ID. It honours stall and redirect requests from later stages and detects the program-termination sequence to drain the pipe and raise HALT.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_AW, 12, instruction-memory byte-address width
- DRAIN_CYCLES, 4, cycles between halt detection and HALT assertion (pipe depth after IF)
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- I_MEM_ADDR  out  IMEM_AW  byte address = PC[IMEM_AW-1:0]
- I_MEM_DI  in  32  instruction word; combinational read of I_MEM_ADDR, valid in the same cycle
- STALL  in  1  hold PC and IF/ID (load-use hazard from ID)
- REDIRECT  in  1  taken branch/jump resolved downstream; squash IF/ID
- REDIRECT_PC  in  32  target PC when REDIRECT=1
- INSTR_IFID  out  32  registered instruction (NOP 32'h0000_0013 when bubble)
- PC_IFID  out  32  registered PC of INSTR_IFID
- PCPLUS4_IFID  out  32  PC_IFID+4 (link value for JAL/JALR)
- VALID_IFID  out  1  IF/ID holds a real instruction
- HALT  out  1  program finished, pipe drained; sticky until reset

## Operation
- FSM states: RUN, ARMED, DRAIN, HALTED.
- RUN/ARMED, per cycle, in priority order:
  - REDIRECT: PC<=REDIRECT_PC; IF/ID<=bubble. Overrides STALL; FSM to RUN.
  - Else STALL: PC and IF/ID hold; FSM holds.
  - Else: IF/ID<={PC, PC+4, I_MEM_DI, 1}; PC<=PC+4.
- Halt detection, on unstalled and unredirected fetches only:
  - RUN fetching 32'h00c0_0093 goes to ARMED.
  - ARMED fetching 32'h0000_8067 goes to DRAIN and loads the drain counter with DRAIN_CYCLES-1.
  - ARMED fetching any other word goes to RUN, or to ARMED if that word is 32'h00c0_0093.
- The final JALR is latched into IF/ID normally.
- DRAIN: PC frozen; IF/ID<=bubble every cycle. STALL and REDIRECT are ignored. Counter decrements; at 0 the FSM goes to HALTED.
- HALTED: PC frozen, bubbles only, HALT=1.
- PC arithmetic: 32-bit, wraps modulo 2^32. PC[1:0] is not checked, and REDIRECT_PC is taken verbatim.
- Bubble: INSTR_IFID=32'h0000_0013, VALID_IFID=0. PC_IFID and PCPLUS4_IFID hold their last values.

## Timing
- Reset values (RST high at a clock edge):
  - PC=RESET_PC, so I_MEM_ADDR=RESET_PC[IMEM_AW-1:0] in the first cycle after reset.
  - INSTR_IFID=32'h0000_0013, PC_IFID=0, PCPLUS4_IFID=0, VALID_IFID=0.
  - FSM=RUN, HALT=0, drain counter=0.
- RST is honoured in every state, including DRAIN and HALTED, and overrides STALL and REDIRECT.
- Fetch latency: 1 cycle. An instruction at PC in cycle n appears on INSTR_IFID in cycle n+1.
- Redirect penalty: the cycle REDIRECT is high produces a bubble in IF/ID in the next cycle. The target instruction appears in IF/ID one cycle after that.
- STALL and REDIRECT are sampled at the clock edge and must be stable before it. There is no handshake back to the driver.
- HALT rises exactly DRAIN_CYCLES cycles after the edge that latches the JALR into IF/ID.

## Configuration
- PIPE_FETCH_CNT_EN defined: adds output FETCH_CNT (32-bit).
  - Increments once per valid instruction latched into IF/ID.
  - Not incremented for stall, bubble or drain cycles.
  - Reset to 0, saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - NOP_INSTR, HALT_WORD0 (32'h00c0_0093), HALT_WORD1 (32'h0000_8067)
  - fetch FSM state enum
  - IF/ID bundle struct {pc, pc_plus4, instr, valid}
- One sub-module, pipe_halt_det, holding the RUN/ARMED/DRAIN/HALTED FSM and the drain counter. Its inputs are the fetched word and a fetch-accepted strobe. Its outputs are freeze and HALT.
- PC register and IF/ID register live in pipe_fetch.

## Test plan
- Reset release, memory returns sequential ADDIs -> I_MEM_ADDR 0,4,8; INSTR_IFID one cycle later with PC_IFID 0,4,8 and PCPLUS4_IFID 4,8,12; VALID_IFID=1 from the 2nd cycle.
- STALL high 2 cycles at PC=8 -> PC stays 8 and IF/ID holds PC_IFID=4 for 2 cycles; resumes at 8.
- REDIRECT with target 0x40 while STALL=1 -> next cycle bubble (INSTR_IFID=0x13, VALID_IFID=0); following cycle PC_IFID=0x40.
- Fetch 0x00c00093, then 0x00008067 -> IF/ID bubbles for DRAIN_CYCLES cycles, HALT=1 at cycle DRAIN_CYCLES, PC frozen; REDIRECT during DRAIN is ignored.
- Fetch 0x00c00093, then an ADDI, then 0x00008067 -> no halt; a REDIRECT while in ARMED also returns the FSM to RUN.
- RST asserted while HALTED -> HALT=0, PC=RESET_PC, VALID_IFID=0; with PIPE_FETCH_CNT_EN, FETCH_CNT=0 and then counts only valid fetches.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, fetch FSM states and IF/ID bundle for the pipeline
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD0 = 32'h00c0_0093;
  localparam logic [31:0] HALT_WORD1 = 32'h0000_8067;
  typedef enum logic [1:0] {RUN, ARMED, DRAIN, HALTED} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
  // PC fields are kept so the link value of the last real instruction stays visible
  function automatic ifid_t to_bubble(input ifid_t f);
    to_bubble       = f;
    to_bubble.instr = NOP_INSTR;
    to_bubble.valid = 1'b0;
  endfunction
endpackage

// File: rtl/pipe_halt_det.sv
// pipe_halt_det: termination-sequence detector with drain counter and sticky halt
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_word           instruction word being fetched this cycle
//   i_accept         fetch is accepted into IF/ID (not stalled, redirected or frozen)
//   i_redirect       downstream redirect; disarms a half-seen termination sequence
//   o_freeze         PC frozen and IF/ID bubbling (draining or halted)
//   o_halt           pipe drained; sticky until reset
module pipe_halt_det
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_word,
  input  logic        i_accept,
  input  logic        i_redirect,
  output logic        o_freeze,
  output logic        o_halt
);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  fetch_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic          r_halt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        RUN:
          if (i_accept && i_word == HALT_WORD0) r_state <= ARMED;
        ARMED:
          if (i_redirect) r_state <= RUN;
          else if (i_accept) begin
            if (i_word == HALT_WORD1) begin
              r_state <= DRAIN;
              r_cnt   <= CW'(DRAIN_CYCLES - 1);
            end else if (i_word != HALT_WORD0) r_state <= RUN;
          end
        DRAIN:
          if (r_cnt == '0) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end else r_cnt <= r_cnt - CW'(1);
        default:
          r_halt <= 1'b1;
      endcase
    end
  end
  assign o_freeze = (r_state == DRAIN) || (r_state == HALTED);
  assign o_halt   = r_halt;
endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: RV32I instruction-fetch stage, PC register and IF/ID pipeline register
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   I_MEM_ADDR / I_MEM_DI    instruction memory byte address / combinational read data
//   STALL                    hold PC and IF/ID
//   REDIRECT / REDIRECT_PC   taken branch/jump: load PC, squash IF/ID
//   INSTR_IFID, PC_IFID,
//   PCPLUS4_IFID, VALID_IFID IF/ID register contents
//   HALT                     termination sequence seen and pipe drained
//   FETCH_CNT                saturating count of valid fetches (only with PIPE_FETCH_CNT_EN)
// Build option: define PIPE_FETCH_CNT_EN to add the FETCH_CNT output and counter.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_AW      = 12,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [IMEM_AW-1:0] I_MEM_ADDR,
  input  logic [31:0]        I_MEM_DI,
  input  logic               STALL,
  input  logic               REDIRECT,
  input  logic [31:0]        REDIRECT_PC,
  output logic [31:0]        INSTR_IFID,
  output logic [31:0]        PC_IFID,
  output logic [31:0]        PCPLUS4_IFID,
  output logic               VALID_IFID,
`ifdef PIPE_FETCH_CNT_EN
  output logic [31:0]        FETCH_CNT,
`endif
  output logic               HALT
);
  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic [31:0] w_pc_plus4;
  logic        w_freeze;
  logic        w_accept;
  assign w_pc_plus4 = r_pc + 32'd4;
  // Freeze wins over redirect and stall so a drain cannot be disturbed downstream
  assign w_accept = !w_freeze && !REDIRECT && !STALL;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc   <= RESET_PC;
      r_ifid <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (w_freeze) begin
      r_ifid <= to_bubble(r_ifid);
    end else if (REDIRECT) begin
      r_pc   <= REDIRECT_PC;
      r_ifid <= to_bubble(r_ifid);
    end else if (!STALL) begin
      r_pc   <= w_pc_plus4;
      r_ifid <= '{pc: r_pc, pc_plus4: w_pc_plus4, instr: I_MEM_DI, valid: 1'b1};
    end
  end
  pipe_halt_det #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_halt_det (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_word     (I_MEM_DI),
    .i_accept   (w_accept),
    .i_redirect (REDIRECT),
    .o_freeze   (w_freeze),
    .o_halt     (HALT)
  );
`ifdef PIPE_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;
  always_ff @(posedge CLK) begin
    if (RST) r_fetch_cnt <= '0;
    else if (w_accept && r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end
  assign FETCH_CNT = r_fetch_cnt;
`endif
  assign I_MEM_ADDR   = r_pc[IMEM_AW-1:0];
  assign INSTR_IFID   = r_ifid.instr;
  assign PC_IFID      = r_ifid.pc;
  assign PCPLUS4_IFID = r_ifid.pc_plus4;
  assign VALID_IFID   = r_ifid.valid;
endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed and randomized check of pipe_fetch against a sequence-level model
module tb_pipe_fetch;
  localparam logic [31:0] W0  = 32'h00c0_0093;
  localparam logic [31:0] W1  = 32'h0000_8067;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DC  = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic [11:0] imem_addr;
  logic [31:0] imem_di;
  logic [31:0] instr, pc_ifid, pc4;
  logic        valid, halt;
`ifdef PIPE_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif
  logic [31:0] mem [1024];
  assign imem_di = mem[imem_addr[11:2]];
  pipe_fetch #(.RESET_PC(32'h0), .IMEM_AW(12), .DRAIN_CYCLES(DC)) dut (
    .CLK          (clk),
    .RST          (rst),
    .I_MEM_ADDR   (imem_addr),
    .I_MEM_DI     (imem_di),
    .STALL        (stall),
    .REDIRECT     (redirect),
    .REDIRECT_PC  (rpc),
    .INSTR_IFID   (instr),
    .PC_IFID      (pc_ifid),
    .PCPLUS4_IFID (pc4),
    .VALID_IFID   (valid),
`ifdef PIPE_FETCH_CNT_EN
    .FETCH_CNT    (fetch_cnt),
`endif
    .HALT         (halt)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  // Model: the PC, the IF/ID contents, and the accepted-fetch stream since the last
  // redirect/reset. A halt begins when W1 is accepted right after an accepted W0.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_prev, m_cnt;
  logic        m_valid, m_halt, m_draining;
  int          m_since;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0;
      m_prev = 0; m_draining = 0; m_since = 0; m_halt = 0; m_cnt = 0;
    end else if (m_draining) begin
      m_instr = NOP; m_valid = 0;
      m_since++;
      if (m_since == DC) m_halt = 1;
    end else if (redirect) begin
      m_pc = rpc; m_instr = NOP; m_valid = 0; m_prev = 0;
    end else if (!stall) begin
      w = mem[m_pc[11:2]];
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = w; m_valid = 1;
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_prev == W0 && w == W1) begin m_draining = 1; m_since = 0; end
      m_prev = w;
    end
  endtask
  task automatic tick(input bit s, input bit r, input logic [31:0] t);
    stall = s; redirect = r; rpc = t;
    @(posedge clk);
    model_step();
    #1;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", 32'(imem_addr), 32'(m_pc[11:0]));
      check("instr_ifid", instr, m_instr);
      check("pc_ifid", pc_ifid, m_ipc);
      check("pcplus4_ifid", pc4, m_ipc4);
      check("valid_ifid", 32'(valid), 32'(m_valid));
      check("halt", 32'(halt), 32'(m_halt));
`ifdef PIPE_FETCH_CNT_EN
      check("fetch_cnt", fetch_cnt, m_cnt);
`endif
    end
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0113 | (i << 20);
    mem[32] = W0; mem[33] = W1;
    mem[48] = W0; mem[50] = W1;
    mem[64] = W0; mem[65] = W1;
    rst = 1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk_en = 1;
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc_ifid, 32'h0);
    check("rst_pc4", pc4, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    rst = 0;
    tick(0, 0, 0);
    check("seq0_addr", 32'(imem_addr), 32'h4);
    check("seq0_pc", pc_ifid, 32'h0);
    check("seq0_pc4", pc4, 32'h4);
    check("seq0_valid", 32'(valid), 32'h1);
    check("seq0_instr", instr, 32'h0000_0113);
    tick(0, 0, 0);
    check("seq1_pc", pc_ifid, 32'h4);
    check("seq1_addr", 32'(imem_addr), 32'h8);
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0);
      check("stall_addr", 32'(imem_addr), 32'h8);
      check("stall_pc", pc_ifid, 32'h4);
    end
    tick(0, 0, 0);
    check("resume_pc", pc_ifid, 32'h8);
    check("resume_pc4", pc4, 32'hC);
    tick(1, 1, 32'h40);
    check("redir_instr", instr, NOP);
    check("redir_valid", 32'(valid), 32'h0);
    tick(0, 0, 0);
    check("redir_tgt_pc", pc_ifid, 32'h40);
    tick(0, 1, 32'h80);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("jalr_latched", instr, W1);
    check("jalr_pc", pc_ifid, 32'h84);
    for (int k = 1; k <= DC; k++) begin
      tick(0, 1, 32'h200);
      check("drain_valid", 32'(valid), 32'h0);
      check("drain_addr", 32'(imem_addr), 32'h88);
      check("drain_halt", 32'(halt), (k == DC) ? 32'h1 : 32'h0);
    end
    tick(1, 1, 32'h300);
    check("halted_sticky", 32'(halt), 32'h1);
    rst = 1;
    tick(1, 1, 32'h300);
    rst = 0;
    check("rst2_halt", 32'(halt), 32'h0);
    check("rst2_addr", 32'(imem_addr), 32'h0);
    check("rst2_valid", 32'(valid), 32'h0);
`ifdef PIPE_FETCH_CNT_EN
    check("rst2_cnt", fetch_cnt, 32'h0);
`endif
    tick(0, 1, 32'hC0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    check("nohalt_pc", pc_ifid, 32'hCC);
    check("nohalt_halt", 32'(halt), 32'h0);
    check("nohalt_valid", 32'(valid), 32'h1);
    tick(0, 1, 32'h100);
    tick(0, 0, 0);
    tick(0, 1, 32'h104);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("disarm_pc", pc_ifid, 32'h108);
    check("disarm_halt", 32'(halt), 32'h0);
    check("disarm_valid", 32'(valid), 32'h1);
    for (int i = 0; i < 1024; i++) begin
      case ($urandom_range(0, 7))
        0: mem[i] = W0;
        1: mem[i] = W1;
        default: mem[i] = $urandom;
      endcase
    end
    rst = 1;
    tick(0, 0, 0);
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
      tick($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom);
      rst = 0;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
